// File: rtl/icache_param_if.sv
// Fetch-side and bus-side signal bundle for icache_param.
// The cache uses the slave modport; the fetch/bus environment uses master.
interface icache_param_if #(
    parameter int LINE_WORDS = 4
);
    logic [31:0]              if_pc_i;
    logic                     if_req_Icache_i;
    logic [31:0]              Icache_inst_o;
    logic                     Icache_ready_o;
    logic                     Icache_hit_o;
    logic                     fc_jump_flag_Icache_i;
    logic                     fence_i_i;
    logic                     flush_busy_o;
    logic [31:0]              Icache_addr_o;
    logic                     Icache_valid_req_o;
    logic                     bc_Icache_ready_i;
    logic [32*LINE_WORDS-1:0] bc_Icache_data_i;

    modport slave (
        input  if_pc_i, if_req_Icache_i, fc_jump_flag_Icache_i, fence_i_i,
               bc_Icache_ready_i, bc_Icache_data_i,
        output Icache_inst_o, Icache_ready_o, Icache_hit_o, flush_busy_o,
               Icache_addr_o, Icache_valid_req_o
    );

    modport master (
        output if_pc_i, if_req_Icache_i, fc_jump_flag_Icache_i, fence_i_i,
               bc_Icache_ready_i, bc_Icache_data_i,
        input  Icache_inst_o, Icache_ready_o, Icache_hit_o, flush_busy_o,
               Icache_addr_o, Icache_valid_req_o
    );
endinterface

// File: rtl/icache_param.sv
// Parametrised set-associative instruction cache with invalid-first/round-robin
// replacement, a one-set-per-cycle FENCE.I walker and jump-tolerant refills.
module icache_param #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    icache_param_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    localparam logic [1:0] LOOKUP = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid    [WAYS];
    logic [WAY_W-1:0]  rr_ptr   [SETS];

    logic [1:0]        state;
    logic [IDX_W-1:0]  flush_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [WORD_W-1:0] lat_word;
    logic [WAY_W-1:0]  lat_way;
    logic              cancel;
    logic              fence_pend;

    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [WORD_W-1:0] pc_word;
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [WAY_W-1:0]  victim;
    logic              found_free;
    logic              accept;
    logic [31:0]       refill_word;
    logic              unused_pc_bits;

    assign pc_idx         = bus.if_pc_i[OFF_W +: IDX_W];
    assign pc_tag         = bus.if_pc_i[31 -: TAG_W];
    assign pc_word        = bus.if_pc_i[OFF_W-1:2];
    assign unused_pc_bits = ^bus.if_pc_i[1:0];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][pc_idx] && (tag_mem[w][pc_idx] == pc_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_line = data_mem[hit_way][pc_idx];
        hit_word = hit_line[pc_word*32 +: 32];
    end

    // Lowest-numbered invalid way wins; a full set falls back to its RR pointer.
    always_comb begin
        victim     = rr_ptr[pc_idx];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_free && !valid[w][pc_idx]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end

    // Data offered in the same cycle as the request pulse is not ours yet.
    assign accept      = (state == REFILL) && bus.bc_Icache_ready_i && !bus.Icache_valid_req_o;
    assign refill_word = bus.bc_Icache_data_i[lat_word*32 +: 32];

    assign bus.Icache_hit_o  = hit_any && (state != FLUSH);
    assign bus.flush_busy_o  = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= LOOKUP;
            bus.Icache_inst_o      <= '0;
            bus.Icache_ready_o     <= 1'b0;
            bus.Icache_addr_o      <= '0;
            bus.Icache_valid_req_o <= 1'b0;
            flush_idx              <= '0;
            lat_tag                <= '0;
            lat_idx                <= '0;
            lat_word               <= '0;
            lat_way                <= '0;
            cancel                 <= 1'b0;
            fence_pend             <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            bus.Icache_valid_req_o <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (bus.fc_jump_flag_Icache_i) begin
                        bus.Icache_ready_o <= 1'b0;
                    end else if (bus.fence_i_i) begin
                        bus.Icache_ready_o <= 1'b0;
                        flush_idx          <= '0;
                        state              <= FLUSH;
                    end else if (bus.if_req_Icache_i) begin
                        if (hit_any) begin
                            bus.Icache_ready_o <= 1'b1;
                            bus.Icache_inst_o  <= hit_word;
                        end else begin
                            bus.Icache_valid_req_o <= 1'b1;
                            bus.Icache_addr_o      <= {bus.if_pc_i[31:OFF_W], {OFF_W{1'b0}}};
                            bus.Icache_ready_o     <= 1'b0;
                            lat_tag                <= pc_tag;
                            lat_idx                <= pc_idx;
                            lat_word               <= pc_word;
                            lat_way                <= victim;
                            cancel                 <= 1'b0;
                            fence_pend             <= 1'b0;
                            state                  <= REFILL;
                        end
                    end else begin
                        bus.Icache_ready_o <= 1'b0;
                        bus.Icache_inst_o  <= '0;
                    end
                end
                REFILL: begin
                    bus.Icache_ready_o <= 1'b0;
                    if (bus.fc_jump_flag_Icache_i) cancel <= 1'b1;
                    if (bus.fence_i_i) fence_pend <= 1'b1;
                    if (accept) begin
                        valid[lat_way][lat_idx] <= 1'b1;
                        rr_ptr[lat_idx]         <= (WAYS > 1) ? lat_way + 1'b1 : '0;
                        if (!(cancel || bus.fc_jump_flag_Icache_i)) begin
                            bus.Icache_ready_o <= 1'b1;
                            bus.Icache_inst_o  <= refill_word;
                        end
                        if (fence_pend || bus.fence_i_i) begin
                            flush_idx <= '0;
                            state     <= FLUSH;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                FLUSH: begin
                    bus.Icache_ready_o <= 1'b0;
                    for (int w = 0; w < WAYS; w++) valid[w][flush_idx] <= 1'b0;
                    rr_ptr[flush_idx] <= '0;
                    if (flush_idx == IDX_W'(SETS - 1)) begin
                        state <= LOOKUP;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= LOOKUP;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            data_mem[lat_way][lat_idx] <= bus.bc_Icache_data_i;
            tag_mem[lat_way][lat_idx]  <= lat_tag;
        end
    end
endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: default 2x8x4 build plus a 4x16x8 build.
module tb_icache_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_param_if #(.LINE_WORDS(4)) a ();
    icache_param_if #(.LINE_WORDS(8)) b ();

    icache_param u_small (.clk(clk), .rst_n(rst_n), .bus(a));
    icache_param #(.WAYS(4), .SETS(16), .LINE_WORDS(8)) u_wide (.clk(clk), .rst_n(rst_n), .bus(b));

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a.if_pc_i = '0; a.if_req_Icache_i = 1'b0; a.fc_jump_flag_Icache_i = 1'b0;
        a.fence_i_i = 1'b0; a.bc_Icache_ready_i = 1'b0; a.bc_Icache_data_i = '0;
        b.if_pc_i = '0; b.if_req_Icache_i = 1'b0; b.fc_jump_flag_Icache_i = 1'b0;
        b.fence_i_i = 1'b0; b.bc_Icache_ready_i = 1'b0; b.bc_Icache_data_i = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Word k of the line at base holds 0x5000_0000 + base + 4k.
    function automatic logic [127:0] mk_line4(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'h5000_0000 + base + 32'(4*k);
        return l;
    endfunction

    function automatic logic [255:0] mk_line8(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h5000_0000 + base + 32'(4*k);
        return l;
    endfunction

    task automatic fill_a(input logic [31:0] pc);
        a.if_pc_i = pc; a.if_req_Icache_i = 1'b1;
        tick;
        a.if_req_Icache_i = 1'b0;
        tick;
        a.bc_Icache_ready_i = 1'b1; a.bc_Icache_data_i = mk_line4(pc & ~32'hF);
        tick;
        a.bc_Icache_ready_i = 1'b0;
    endtask

    task automatic fill_b(input logic [31:0] pc);
        b.if_pc_i = pc; b.if_req_Icache_i = 1'b1;
        tick;
        b.if_req_Icache_i = 1'b0;
        tick;
        b.bc_Icache_ready_i = 1'b1; b.bc_Icache_data_i = mk_line8(pc & ~32'h1F);
        tick;
        b.bc_Icache_ready_i = 1'b0;
    endtask

    task automatic probe_a(input logic [31:0] pc, output logic h);
        a.if_pc_i = pc;
        #1;
        h = a.Icache_hit_o;
    endtask

    task automatic probe_b(input logic [31:0] pc, output logic h);
        b.if_pc_i = pc;
        #1;
        h = b.Icache_hit_o;
    endtask

    task automatic test_reset;
        logic h;
        do_reset;
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b want 0", a.Icache_ready_o); end
        checks++; if (a.Icache_valid_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_req got %0b want 0", a.Icache_valid_req_o); end
        checks++; if (a.Icache_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", a.Icache_addr_o); end
        checks++; if (a.Icache_inst_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h want 0", a.Icache_inst_o); end
        checks++; if (a.flush_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", a.flush_busy_o); end
        probe_a(32'h100, h);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got %0b want 0", h); end
    endtask

    task automatic test_miss_refill;
        a.if_pc_i = 32'h100; a.if_req_Icache_i = 1'b1;
        #1;
        checks++; if (a.Icache_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_hit got %0b want 0", a.Icache_hit_o); end
        tick;
        checks++; if (a.Icache_valid_req_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_valid_req got %0b want 1", a.Icache_valid_req_o); end
        checks++; if (a.Icache_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL miss_addr got %h want 00000100", a.Icache_addr_o); end
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_ready got %0b want 0", a.Icache_ready_o); end
        a.if_req_Icache_i = 1'b0;
        tick;
        checks++; if (a.Icache_valid_req_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_pulse got %0b want 0", a.Icache_valid_req_o); end
        a.bc_Icache_ready_i = 1'b1;
        a.bc_Icache_data_i = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        tick;
        a.bc_Icache_ready_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL refill_ready got %0b want 1", a.Icache_ready_o); end
        checks++; if (a.Icache_inst_o !== 32'h1111_1111) begin errors++; $display("[TB] FAIL refill_inst got %h want 11111111", a.Icache_inst_o); end
        tick;
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL refill_single got %0b want 0", a.Icache_ready_o); end
        a.if_pc_i = 32'h108; a.if_req_Icache_i = 1'b1;
        #1;
        checks++; if (a.Icache_hit_o !== 1'b1) begin errors++; $display("[TB] FAIL hit108 got %0b want 1", a.Icache_hit_o); end
        tick;
        checks++; if (a.Icache_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL hit108_ready got %0b want 1", a.Icache_ready_o); end
        checks++; if (a.Icache_inst_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL hit108_inst got %h want deadbeef", a.Icache_inst_o); end
        a.if_req_Icache_i = 1'b0;
        tick;
        checks++; if (a.Icache_ready_o !== 1'b0 || a.Icache_inst_o !== 32'h0) begin errors++; $display("[TB] FAIL idle_out got ready=%0b inst=%h want 0/0", a.Icache_ready_o, a.Icache_inst_o); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pcs  [3] = '{32'h100, 32'h104, 32'h10C};
        logic [31:0] exps [3] = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
        a.if_req_Icache_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a.if_pc_i = pcs[i];
            tick;
            checks++;
            if (a.Icache_ready_o !== 1'b1 || a.Icache_inst_o !== exps[i]) begin
                errors++;
                $display("[TB] FAIL b2b_%0d got ready=%0b inst=%h want 1/%h", i, a.Icache_ready_o, a.Icache_inst_o, exps[i]);
            end
        end
        a.if_req_Icache_i = 1'b0;
        tick;
    endtask

    task automatic test_early_ready;
        a.if_pc_i = 32'h214; a.if_req_Icache_i = 1'b1;
        tick;
        a.if_req_Icache_i = 1'b0;
        a.bc_Icache_ready_i = 1'b1; a.bc_Icache_data_i = mk_line4(32'h210);
        tick;
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL early_ready got %0b want 0", a.Icache_ready_o); end
        tick;
        a.bc_Icache_ready_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b1 || a.Icache_inst_o !== 32'h5000_0214) begin errors++; $display("[TB] FAIL late_accept got ready=%0b inst=%h want 1/50000214", a.Icache_ready_o, a.Icache_inst_o); end
        tick;
    endtask

    task automatic test_replacement;
        logic [2:0] hv;
        do_reset;
        fill_a(32'h000);
        fill_a(32'h080);
        probe_a(32'h000, hv[0]); probe_a(32'h080, hv[1]);
        checks++; if (hv[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL repl_two got %b want 11", hv[1:0]); end
        fill_a(32'h100);
        probe_a(32'h000, hv[0]); probe_a(32'h080, hv[1]); probe_a(32'h100, hv[2]);
        checks++; if (hv !== 3'b110) begin errors++; $display("[TB] FAIL repl_third got %b want 110", hv); end
        fill_a(32'h180);
        probe_a(32'h080, hv[0]); probe_a(32'h100, hv[1]); probe_a(32'h180, hv[2]);
        checks++; if (hv !== 3'b110) begin errors++; $display("[TB] FAIL repl_fourth got %b want 110", hv); end
    endtask

    task automatic test_jump_cancel;
        logic h;
        do_reset;
        a.if_pc_i = 32'h040; a.if_req_Icache_i = 1'b1;
        tick;
        checks++; if (a.Icache_valid_req_o !== 1'b1) begin errors++; $display("[TB] FAIL jc_valid_req got %0b want 1", a.Icache_valid_req_o); end
        a.if_req_Icache_i = 1'b0;
        tick;
        tick;
        a.fc_jump_flag_Icache_i = 1'b1;
        tick;
        a.fc_jump_flag_Icache_i = 1'b0;
        tick;
        tick;
        a.bc_Icache_ready_i = 1'b1; a.bc_Icache_data_i = mk_line4(32'h040);
        tick;
        a.bc_Icache_ready_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL jc_ready got %0b want 0", a.Icache_ready_o); end
        a.if_pc_i = 32'h044; a.if_req_Icache_i = 1'b1;
        #1;
        checks++; if (a.Icache_hit_o !== 1'b1) begin errors++; $display("[TB] FAIL jc_kept got %0b want 1", a.Icache_hit_o); end
        tick;
        a.if_req_Icache_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b1 || a.Icache_inst_o !== 32'h5000_0044) begin errors++; $display("[TB] FAIL jc_rehit got ready=%0b inst=%h want 1/50000044", a.Icache_ready_o, a.Icache_inst_o); end
        a.if_pc_i = 32'h0C0; a.if_req_Icache_i = 1'b1;
        tick;
        a.if_req_Icache_i = 1'b0;
        tick;
        a.bc_Icache_ready_i = 1'b1; a.fc_jump_flag_Icache_i = 1'b1; a.bc_Icache_data_i = mk_line4(32'h0C0);
        tick;
        a.bc_Icache_ready_i = 1'b0; a.fc_jump_flag_Icache_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL jump_same_ready got %0b want 0", a.Icache_ready_o); end
        probe_a(32'h0C0, h);
        checks++; if (h !== 1'b1) begin errors++; $display("[TB] FAIL jump_same_fill got %0b want 1", h); end
    endtask

    task automatic test_fence;
        logic [3:0] hv;
        int cnt;
        do_reset;
        for (int i = 0; i < 4; i++) fill_a(32'(i * 16));
        for (int i = 0; i < 4; i++) probe_a(32'(i * 16), hv[i]);
        checks++; if (hv !== 4'b1111) begin errors++; $display("[TB] FAIL fence_pre got %b want 1111", hv); end
        a.fence_i_i = 1'b1;
        tick;
        a.fence_i_i = 1'b0;
        a.if_pc_i = 32'h030;
        #1;
        checks++; if (a.Icache_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_hit_forced got %0b want 0", a.Icache_hit_o); end
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (a.flush_busy_o === 1'b1) cnt++;
            tick;
        end
        checks++; if (cnt != 8) begin errors++; $display("[TB] FAIL fence_busy_cycles got %0d want 8", cnt); end
        for (int i = 0; i < 4; i++) probe_a(32'(i * 16), hv[i]);
        checks++; if (hv !== 4'b0000) begin errors++; $display("[TB] FAIL fence_post got %b want 0000", hv); end
    endtask

    task automatic test_fence_in_refill;
        logic h;
        int cnt;
        do_reset;
        a.if_pc_i = 32'h050; a.if_req_Icache_i = 1'b1;
        tick;
        a.if_req_Icache_i = 1'b0;
        tick;
        a.fence_i_i = 1'b1;
        tick;
        a.fence_i_i = 1'b0;
        a.bc_Icache_ready_i = 1'b1; a.bc_Icache_data_i = mk_line4(32'h050);
        tick;
        a.bc_Icache_ready_i = 1'b0;
        checks++; if (a.Icache_ready_o !== 1'b1 || a.Icache_inst_o !== 32'h5000_0050) begin errors++; $display("[TB] FAIL fr_ready got ready=%0b inst=%h want 1/50000050", a.Icache_ready_o, a.Icache_inst_o); end
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (a.flush_busy_o === 1'b1) cnt++;
            tick;
        end
        checks++; if (cnt != 8) begin errors++; $display("[TB] FAIL fr_busy_cycles got %0d want 8", cnt); end
        probe_a(32'h050, h);
        checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL fr_post_hit got %0b want 0", h); end
    endtask

    task automatic test_wide_build;
        logic [4:0] hv;
        logic [1:0] hv2;
        do_reset;
        b.if_pc_i = 32'h21C; b.if_req_Icache_i = 1'b1;
        tick;
        b.if_req_Icache_i = 1'b0;
        checks++; if (b.Icache_valid_req_o !== 1'b1 || b.Icache_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL wide_addr got req=%0b addr=%h want 1/00000200", b.Icache_valid_req_o, b.Icache_addr_o); end
        tick;
        b.bc_Icache_ready_i = 1'b1; b.bc_Icache_data_i = mk_line8(32'h200);
        tick;
        b.bc_Icache_ready_i = 1'b0;
        checks++; if (b.Icache_ready_o !== 1'b1 || b.Icache_inst_o !== 32'h5000_021C) begin errors++; $display("[TB] FAIL wide_word7 got ready=%0b inst=%h want 1/5000021c", b.Icache_ready_o, b.Icache_inst_o); end
        fill_b(32'h400);
        fill_b(32'h600);
        fill_b(32'h800);
        fill_b(32'hA00);
        probe_b(32'h200, hv[0]); probe_b(32'h400, hv[1]); probe_b(32'h600, hv[2]);
        probe_b(32'h800, hv[3]); probe_b(32'hA00, hv[4]);
        checks++; if (hv !== 5'b11110) begin errors++; $display("[TB] FAIL wide_fifth got %b want 11110", hv); end
        fill_b(32'hC00);
        probe_b(32'h400, hv2[0]); probe_b(32'h600, hv2[1]);
        checks++; if (hv2 !== 2'b10) begin errors++; $display("[TB] FAIL wide_sixth got %b want 10", hv2); end
    endtask

    initial begin
        idle_inputs;
        test_reset;
        test_miss_refill;
        test_back_to_back;
        test_early_ready;
        test_replacement;
        test_jump_cancel;
        test_fence;
        test_fence_in_refill;
        test_wide_build;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_param.md
# icache_param

Parametrised set-associative instruction cache; successor to the fixed 2-way/8-set fetch cache. It sits between the IF stage / fetch controller and the bus controller, and serves one 32-bit instruction per request. Over the fixed design it adds configurable way count, set count and line size, deterministic invalid-first/round-robin replacement, a FENCE.I flush walker, and jump cancellation that keeps an in-flight refill instead of dropping it.

## Interface
Parameters:
- WAYS, 2: associativity; power of 2, 1..4.
- SETS, 8: number of sets; power of 2, 2..64.
- LINE_WORDS, 4: 32-bit words per line; power of 2, 2..8.

Address split: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = 32-OFF_W-IDX_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_pc_i  in  32  fetch address; bits [1:0] ignored.
- if_req_Icache_i  in  1  fetch request, sampled each cycle.
- Icache_inst_o  out  32  registered instruction.
- Icache_ready_o  out  1  registered; Icache_inst_o valid this cycle.
- Icache_hit_o  out  1  combinational lookup hit for if_pc_i.
- fc_jump_flag_Icache_i  in  1  flush/redirect from fetch controller.
- fence_i_i  in  1  one-cycle pulse; invalidate whole cache.
- flush_busy_o  out  1  high while the invalidate walk runs.
- Icache_addr_o  out  32  line-aligned refill address (low OFF_W bits zero).
- Icache_valid_req_o  out  1  one-cycle refill request pulse.
- bc_Icache_ready_i  in  1  refill data valid (one cycle).
- bc_Icache_data_i  in  32*LINE_WORDS  refill line; word k at [32k+31:32k].

## Operation
- Storage: data array, tag array, per-line valid bit, and per-set round-robin pointer (log2(WAYS) bits; none when WAYS=1).
- Reset (rst_n=0 at clock edge): Icache_inst_o=0, Icache_ready_o=0, Icache_addr_o=0, Icache_valid_req_o=0, flush_busy_o=0. All valid bits and RR pointers are cleared; state goes to LOOKUP. Reset mid-refill abandons it; a later bc_Icache_ready_i is ignored.
- Icache_hit_o = OR over ways of (valid & tag match) at index if_pc_i; forced 0 in FLUSH.
- States:
  - LOOKUP, jump=1: no lookup, ready<=0.
  - LOOKUP, fence_i_i=1: go to FLUSH; a concurrent request is dropped and must be re-issued.
  - LOOKUP, req & hit: ready<=1; inst<=word if_pc_i[OFF_W-1:2] of the hit way.
  - LOOKUP, req & miss: valid_req<=1; addr<=line-aligned if_pc_i; ready<=0. Latch tag, index, word offset and the victim way, then go to REFILL.
  - LOOKUP, no req: ready<=0, inst<=0.
  - REFILL: valid_req<=0 after its first cycle. A jump sets a cancel flag; a fence_i_i sets a fence-pending flag. On bc_Icache_ready_i, write line, tag and valid into the victim way and advance that set's RR pointer to victim+1 mod WAYS. If the cancel flag (or jump this cycle) is clear, ready<=1 and inst<=latched-offset word of the incoming data. Then go to FLUSH if fence-pending, else LOOKUP.
  - FLUSH: flush_busy_o=1 and ready=0. Clear the valid bits of one set per cycle, set 0 to SETS-1, and reset RR pointers. After set SETS-1, go to LOOKUP. Requests and jumps are ignored.
- Victim choice: the lowest-numbered invalid way in the set; if all are valid, the way given by the RR pointer.
- Hits do not change replacement state.

## Timing
- Hit: request in cycle N -> ready=1 with data in N+1. Back-to-back hits give ready every cycle.
- Miss: request in N -> valid_req=1 and addr in N+1. bc_Icache_ready_i in cycle M (M>=N+2) -> ready=1 in M+1; LOOKUP resumes in M+1.
- A bc_Icache_ready_i in the same cycle as valid_req is not accepted.
- Fence: fence_i_i in N -> flush_busy_o=1 from N+1 through N+SETS; LOOKUP in N+SETS+1.
- Simultaneous jump and bc_Icache_ready_i: line is filled, ready stays 0.
- Icache_ready_o is never high in two consecutive cycles for a single miss.

## Test plan
- Reset, then req pc=0x100, miss: valid_req pulse with addr=0x100. Return a line with word2=0xDEADBEEF, then req pc=0x108: hit; ready next cycle with inst=0xDEADBEEF.
- Default params, three addresses 0x000, 0x080, 0x100 in set 0. Fill first two, then miss third: it evicts way 0 (RR=0). A fourth miss at 0x180 evicts way 1.
- Jump asserted 2 cycles after valid_req, bc ready 3 cycles later: ready stays 0. Next req to same line hits.
- fence_i_i after 4 lines are filled: flush_busy high exactly 8 cycles; all prior addresses miss afterwards.
- fence_i_i during REFILL: refill completes with ready=1, then an 8-cycle flush runs. The just-filled line then misses.
- WAYS=4, SETS=16, LINE_WORDS=8 build: addr low 5 bits zero on miss. Word 7 (pc=0x1C) is returned correctly; 5 conflicting lines replace ways in order 0,1,2,3,0.
